// File: rtl/fft_tile_scheduler.sv
// fft_tile_scheduler: issue/collect sequencer for the 4x4 2-D forward-FFT tile
// datapath. Pulls tile cachelines from a valid/ready stream, raises the
// datapath's one-cycle-early fft_next strobe, presents the data a cycle later,
// and tags each result strobe with its tile index. Issue is gated on
// downstream credits because the FFT pipeline cannot be stalled.
// Optional build macro: FFT_SCHED_PERF_EN adds busy/stall performance counters.
module fft_tile_scheduler #(
    parameter int TILE_IDX_W  = 16,
    parameter int MAX_CREDITS = 8,
    parameter int MIN_GAP     = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [TILE_IDX_W-1:0] num_tiles,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [511:0]          in_data,
    output logic                  fft_next,
    output logic [511:0]          fft_data,
    input  logic                  fft_next_out,
    output logic                  out_valid,
    output logic [TILE_IDX_W-1:0] out_tile_idx,
    input  logic                  credit_return
`ifdef FFT_SCHED_PERF_EN
    ,
    output logic [31:0]           perf_busy_cycles,
    output logic [31:0]           perf_stall_cycles
`endif
);

    localparam int CRED_W = $clog2(MAX_CREDITS) + 1;
    localparam int PTR_W  = $clog2(MAX_CREDITS);
    localparam int GAP_W  = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state, w_next_state;
    logic [1:0]            r_rst_sync;
    logic                  w_rst_n;

    logic [TILE_IDX_W-1:0] r_num_tiles;
    logic [TILE_IDX_W-1:0] r_issued;
    logic [GAP_W-1:0]      r_gap;
    logic [CRED_W-1:0]     r_credits;

    logic [TILE_IDX_W-1:0] r_tag_mem [MAX_CREDITS];
    logic [PTR_W:0]        r_wr_ptr;
    logic [PTR_W:0]        r_rd_ptr;

    logic [511:0]          r_stage1;
    logic [511:0]          r_stage2;
    logic                  r_fft_next;
    logic                  r_out_valid;
    logic [TILE_IDX_W-1:0] r_out_idx;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    logic                  w_in_ready;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_start_acc;
    logic                  w_hs;
    logic                  w_fifo_empty;
    logic                  w_fifo_full;
    logic                  w_pop;
    logic                  w_nxo_err;
    logic                  w_cr_full;
    logic                  w_cr_err;
    logic                  w_cr_inc;

    assign w_start_acc  = start && (r_state == S_IDLE);
    assign w_hs         = in_valid && w_in_ready;
    assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
    assign w_fifo_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                          (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_pop        = fft_next_out && !w_fifo_empty;
    assign w_nxo_err    = fft_next_out && w_fifo_empty;
    // A return at full credits is only legal when an issue consumes one in the same cycle.
    assign w_cr_full    = (r_credits == CRED_W'(MAX_CREDITS));
    assign w_cr_err     = credit_return && w_cr_full && !w_hs;
    assign w_cr_inc     = credit_return && !w_cr_err;

    // Reset asserts asynchronously, releases two clocks after reset_n rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // FSM state register.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next_state = (num_tiles == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (w_hs && ((r_issued + TILE_IDX_W'(1)) == r_num_tiles))
                    w_next_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_fifo_empty && !r_fft_next) w_next_state = S_DONE;
            end
            S_DONE: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // FSM outputs: issue gate plus status levels that get registered below.
    always_comb begin
        w_in_ready = (r_state == S_RUN) && (r_credits != '0) &&
                     (r_issued < r_num_tiles) && (r_gap == '0) && !w_fifo_full;
        w_busy     = (r_state != S_IDLE);
        w_done     = (r_state == S_DONE);
    end

    // Job length latch and issued-tile count.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_num_tiles <= '0;
            r_issued    <= '0;
        end else if (w_start_acc) begin
            r_num_tiles <= num_tiles;
            r_issued    <= '0;
        end else if (w_hs) begin
            r_issued    <= r_issued + TILE_IDX_W'(1);
        end
    end

    // Minimum spacing between issues; reloaded on every handshake.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n)          r_gap <= '0;
        else if (w_hs)         r_gap <= GAP_W'(MIN_GAP - 1);
        else if (r_gap != '0)  r_gap <= r_gap - GAP_W'(1);
    end

    // Downstream credit counter; issue consumes, credit_return refunds (saturating).
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_credits <= CRED_W'(MAX_CREDITS);
        end else begin
            case ({w_hs, w_cr_inc})
                2'b10:   r_credits <= r_credits - CRED_W'(1);
                2'b01:   r_credits <= r_credits + CRED_W'(1);
                default: r_credits <= r_credits;
            endcase
        end
    end

    // Tag FIFO pointers: push issued index on handshake, pop on each result strobe.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_hs)  r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
        end
    end

    // Tag FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (w_hs) r_tag_mem[r_wr_ptr[PTR_W-1:0]] <= r_issued;
    end

    // Two-stage data path: fft_next leads the data it announces by one cycle.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_stage1   <= '0;
            r_stage2   <= '0;
            r_fft_next <= 1'b0;
        end else begin
            r_fft_next <= w_hs;
            if (w_hs)       r_stage1 <= in_data;
            if (r_fft_next) r_stage2 <= r_stage1;
        end
    end

    // Result tagging: index appears with out_valid the cycle after fft_next_out.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
        end else begin
            r_out_valid <= w_pop;
            if (w_pop) r_out_idx <= r_tag_mem[r_rd_ptr[PTR_W-1:0]];
        end
    end

    // Registered status; busy/done trail the state by a cycle so busy drops with done.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= w_busy;
            r_done <= w_done;
            r_err  <= (r_err && !w_start_acc) || w_nxo_err || w_cr_err;
        end
    end

`ifdef FFT_SCHED_PERF_EN
    logic [31:0] r_perf_busy;
    logic [31:0] r_perf_stall;

    // Saturating counters of active cycles and input-stall cycles, cleared per job.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else if (w_start_acc) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else begin
            if (((r_state == S_RUN) || (r_state == S_DRAIN)) && !(&r_perf_busy))
                r_perf_busy <= r_perf_busy + 32'd1;
            if ((r_state == S_RUN) && in_valid && !w_in_ready && !(&r_perf_stall))
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_busy_cycles  = r_perf_busy;
    assign perf_stall_cycles = r_perf_stall;
`endif

    assign in_ready     = w_in_ready;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;
    assign fft_next     = r_fft_next;
    assign fft_data     = r_stage2;
    assign out_valid    = r_out_valid;
    assign out_tile_idx = r_out_idx;

endmodule

// File: doc/fft_tile_scheduler.md
Name: fft_tile_scheduler

Overview:
- Sequences the 4x4 2-D forward-FFT tile datapath (cacheline in, complex 4x4 tile out).
- Pulls tile cachelines from a valid/ready read-response stream, issues the datapath's one-cycle-early `next` strobe, and delivers the data one cycle later.
- Matches each datapath `next_out` to its tile index and gates issue on downstream buffer credits, because the FFT pipeline cannot stall.

Parameters:
- TILE_IDX_W, 16, width of tile count and tile index.
- MAX_CREDITS, 8, downstream result-buffer slots; also the tag FIFO depth (power of 2).
- MIN_GAP, 1, minimum cycles between consecutive fft_next pulses (1 = every cycle).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a job (accepted only in IDLE).
- num_tiles  in  TILE_IDX_W  tiles in the job, sampled on start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at job end.
- err  out  1  sticky protocol-error flag; cleared only on start.
- in_valid  in  1  cacheline available.
- in_ready  out  1  cacheline accepted this cycle.
- in_data  in  512  tile cacheline.
- fft_next  out  1  datapath strobe; data is valid on the following cycle.
- fft_data  out  512  cacheline to the datapath.
- fft_next_out  in  1  datapath result strobe; result is valid on the following cycle.
- out_valid  out  1  result valid at the datapath output this cycle.
- out_tile_idx  out  TILE_IDX_W  index of that result.
- credit_return  in  1  one downstream slot freed.

Behaviour:
Interface
- Single clock domain.
- reset_n is asynchronous and active-low; reset is asserted asynchronously and released synchronously to clk.
- Reset values: all outputs 0, state IDLE, credits = MAX_CREDITS, tag FIFO empty, counters 0.

FSM
- IDLE: on start, latch num_tiles, clear err, clear issued count, go to RUN. If num_tiles = 0, go directly to DONE.
- RUN: in_ready = in_valid-independent AND credits > 0 AND issued < num_tiles AND gap counter expired AND tag FIFO not full.
  - Handshake (in_valid AND in_ready) in cycle N:
    - Capture in_data into stage 1.
    - Push the issued index into the tag FIFO.
    - Decrement credits; increment issued.
    - Reload the gap counter with MIN_GAP-1.
  - Cycle N+1: fft_next = 1, and stage 1 moves to stage 2.
  - Cycle N+2: fft_data = stage 2. fft_data holds its last value otherwise.
  - When issued reaches num_tiles, go to DRAIN.
- DRAIN: wait until the tag FIFO is empty and no fft_next is pending, then go to DONE.
- DONE: done = 1 for one cycle, then IDLE. busy is 0 in the same cycle done falls.

Results
- fft_next_out in cycle M causes out_valid = 1 in cycle M+1, with out_tile_idx = the popped tag.
- Tags pop in FIFO order; the datapath preserves order.
- fft_next_out with the tag FIFO empty sets err, produces no out_valid, and leaves state unchanged.

Credits
- Counter width is clog2(MAX_CREDITS)+1 bits.
- Simultaneous issue and credit_return in one cycle: net unchanged.
- credit_return at MAX_CREDITS: ignored (saturates) and sets err.

Other rules
- start outside IDLE: ignored, no err.
- Reset mid-job: all state discarded immediately; no done pulse.
- MIN_GAP = 1: back-to-back handshakes, giving one fft_next per cycle.

Optional Feature:
- Macro: FFT_SCHED_PERF_EN.
- Defined: adds outputs perf_busy_cycles (32 bits; counts cycles in RUN or DRAIN) and perf_stall_cycles (32 bits; counts RUN cycles where in_valid = 1 and in_ready = 0).
  - Both counters clear on start and saturate at all-ones.
- Undefined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Normal job: num_tiles = 4, in_valid always 1, credit_return 3 cycles after each out_valid, datapath model latency 10 → 4 fft_next pulses in consecutive cycles; fft_data matches in_data one cycle after each pulse; out_tile_idx 0,1,2,3; done pulses once; err = 0.
- Credit stall: MAX_CREDITS = 8, num_tiles = 12, no credit_return → exactly 8 handshakes, then in_ready = 0. Returning 4 credits releases the remaining 4 tiles; done follows the final out_valid.
- Gap: MIN_GAP = 4, num_tiles = 3 → fft_next pulses spaced exactly 4 cycles apart.
- Boundaries: num_tiles = 0 → done 2 cycles after start, with no fft_next. A second start while busy is ignored. Simultaneous issue and credit_return leaves the credit count unchanged.
- Errors: fft_next_out with no tiles in flight → err = 1 and out_valid = 0. credit_return at full credits → err = 1. The next start clears err.
- Async reset mid-DRAIN with 2 tiles in flight → all outputs 0 immediately. After release: IDLE, credits = 8, no done pulse.
